// File: rtl/pulse_frame_gen_if.sv
// Per-pulse frame interface: session control and trigger in, frame window and status out.
// The master drives session control; the slave is the frame generator.
interface pulse_frame_gen_if #(
   parameter int CNT_W = 16,
   parameter int LEN_W = 12,
   parameter int DLY_W = 12
);
   logic             Capture_En;
   logic             trigger_i;
   logic [DLY_W-1:0] delay_i;
   logic [LEN_W-1:0] frame_len_i;
   logic [CNT_W-1:0] pulse_total_i;
   logic             data_valid_o;
   logic [CNT_W-1:0] frame_cnt_o;
   logic             first_frame_o;
   logic             capture_done_o;
   logic             busy_o;
   logic [7:0]       trig_miss_o;

   modport master (
      output Capture_En, trigger_i, delay_i, frame_len_i, pulse_total_i,
      input  data_valid_o, frame_cnt_o, first_frame_o, capture_done_o, busy_o, trig_miss_o
   );

   modport slave (
      input  Capture_En, trigger_i, delay_i, frame_len_i, pulse_total_i,
      output data_valid_o, frame_cnt_o, first_frame_o, capture_done_o, busy_o, trig_miss_o
   );
endinterface

// File: rtl/pulse_frame_gen.sv
// Per-trigger data_valid frame generator with delay, gap, pulse budget and miss counting.
// Optional macro TRIG_SYNC_EN adds a 2-flop synchronizer ahead of the trigger sample register.
module pulse_frame_gen #(
   parameter int CNT_W   = 16,
   parameter int LEN_W   = 12,
   parameter int DLY_W   = 12,
   parameter int GAP_CYC = 8
) (
   input logic             clk,
   input logic             rst,
   pulse_frame_gen_if.slave bus
);

   localparam int GAP_W = $clog2(GAP_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
   localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_DELAY, S_ACTIVE, S_GAP, S_DONE
   } state_t;

   state_t           state;
   logic [DLY_W-1:0] cfg_dly;
   logic [DLY_W-1:0] dly_cnt;
   logic [LEN_W-1:0] cfg_len;
   logic [LEN_W-1:0] act_cnt;
   logic [LEN_W-1:0] len_eff;
   logic [CNT_W-1:0] cfg_total;
   logic [CNT_W-1:0] frame_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [7:0]       miss_cnt;
   logic             any_frame;
   logic             dv_q;
   logic             first_q;
   logic             done_q;
   logic             busy_q;
   logic             trig_s;
   logic             trig_s_d;
   logic             trig_edge;
   logic             in_busy;

`ifdef TRIG_SYNC_EN
   logic trig_m1;
   logic trig_m2;

   always_ff @(posedge clk) begin
      if (rst) begin
         trig_m1  <= 1'b0;
         trig_m2  <= 1'b0;
         trig_s   <= 1'b0;
         trig_s_d <= 1'b0;
      end else begin
         trig_m1  <= bus.trigger_i;
         trig_m2  <= trig_m1;
         trig_s   <= trig_m2;
         trig_s_d <= trig_s;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_s   <= 1'b0;
         trig_s_d <= 1'b0;
      end else begin
         trig_s   <= bus.trigger_i;
         trig_s_d <= trig_s;
      end
   end
`endif

   always_comb begin
      trig_edge = trig_s & ~trig_s_d;
      len_eff   = (cfg_len == '0) ? LEN_ONE : cfg_len;
      in_busy   = (state == S_DELAY) || (state == S_ACTIVE) || (state == S_GAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cfg_dly   <= '0;
         cfg_len   <= '0;
         cfg_total <= '0;
         dly_cnt   <= '0;
         act_cnt   <= '0;
         gap_cnt   <= '0;
         frame_cnt <= '0;
         miss_cnt  <= '0;
         any_frame <= 1'b0;
         dv_q      <= 1'b0;
         first_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else if (!bus.Capture_En) begin
         state     <= S_IDLE;
         frame_cnt <= '0;
         miss_cnt  <= '0;
         any_frame <= 1'b0;
         dv_q      <= 1'b0;
         first_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         if (trig_edge && in_busy && (miss_cnt != 8'hFF))
            miss_cnt <= miss_cnt + 8'd1;

         case (state)
            S_IDLE: begin
               cfg_dly   <= bus.delay_i;
               cfg_len   <= bus.frame_len_i;
               cfg_total <= bus.pulse_total_i;
               state     <= S_ARM;
            end
            S_ARM: begin
               if (trig_edge) begin
                  busy_q <= 1'b1;
                  if (cfg_dly == '0) begin
                     state   <= S_ACTIVE;
                     act_cnt <= len_eff;
                     dv_q    <= 1'b1;
                     first_q <= ~any_frame;
                  end else begin
                     state   <= S_DELAY;
                     dly_cnt <= cfg_dly;
                  end
               end
            end
            S_DELAY: begin
               if (dly_cnt == DLY_ONE) begin
                  state   <= S_ACTIVE;
                  act_cnt <= len_eff;
                  dv_q    <= 1'b1;
                  first_q <= ~any_frame;
               end else begin
                  dly_cnt <= dly_cnt - DLY_ONE;
               end
            end
            S_ACTIVE: begin
               if (act_cnt == LEN_ONE) begin
                  state     <= S_GAP;
                  gap_cnt   <= GAP_LOAD;
                  dv_q      <= 1'b0;
                  first_q   <= 1'b0;
                  frame_cnt <= frame_cnt + CNT_ONE;
                  any_frame <= 1'b1;
               end else begin
                  act_cnt <= act_cnt - LEN_ONE;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_ONE) begin
                  busy_q <= 1'b0;
                  // frame_cnt already holds the post-increment value here
                  if ((cfg_total != '0) && (frame_cnt == cfg_total)) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= S_ARM;
                  end
               end else begin
                  gap_cnt <= gap_cnt - GAP_ONE;
               end
            end
            S_DONE: begin
               done_q <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.data_valid_o   = dv_q;
   assign bus.frame_cnt_o    = frame_cnt;
   assign bus.first_frame_o  = first_q;
   assign bus.capture_done_o = done_q;
   assign bus.busy_o         = busy_q;
   assign bus.trig_miss_o    = miss_cnt;

endmodule

// File: tb/tb_pulse_frame_gen.sv
// Scoreboard bench for pulse_frame_gen: stimulus predicts frame windows from trigger times,
// a negedge monitor measures each data_valid window and compares it against the queue.
module tb_pulse_frame_gen;
   localparam int CNT_W   = 4;
   localparam int LEN_W   = 12;
   localparam int DLY_W   = 12;
   localparam int GAP_CYC = 3;
   localparam int unsigned CNT_MOD = 1 << CNT_W;

   logic clk = 1'b0;
   logic rst;
   int unsigned cyc = 0;
   int nvec = 0;
   int nerr = 0;

   pulse_frame_gen_if #(.CNT_W(CNT_W), .LEN_W(LEN_W), .DLY_W(DLY_W)) bus ();

   pulse_frame_gen #(
      .CNT_W(CNT_W), .LEN_W(LEN_W), .DLY_W(DLY_W), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned start;
      int unsigned len;
      bit          first;
      int unsigned cnt;
   } frame_t;

   frame_t expq[$];

   // Session-level reference: when the generator is next ready, when it finishes, what it counted.
   int unsigned m_d, m_len, m_total;
   int unsigned m_armed, m_done_at, m_frames, m_miss;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cfg(input int unsigned d, input int unsigned len, input int unsigned total);
      bus.delay_i       = DLY_W'(d);
      bus.frame_len_i   = LEN_W'(len);
      bus.pulse_total_i = CNT_W'(total);
      m_d       = d;
      m_len     = len;
      m_total   = total;
      m_armed   = cyc + 1;
      m_done_at = 32'hFFFF_FFFF;
      m_frames  = 0;
      m_miss    = 0;
   endtask

   task automatic model_edge(input int unsigned t);
      frame_t f;
      int unsigned l;
      if (t >= m_done_at) return;
      if (t >= m_armed) begin
         l = (m_len == 0) ? 1 : m_len;
         f.start = t + 1 + m_d;
         f.len   = l;
         f.first = (m_frames == 0);
         f.cnt   = (m_frames + 1) % CNT_MOD;
         expq.push_back(f);
         m_frames++;
         m_armed = t + m_d + l + GAP_CYC + 1;
         if (m_total != 0 && m_frames == m_total) m_done_at = m_armed;
      end else if (m_miss < 255) begin
         m_miss++;
      end
   endtask

   task automatic start_session(input int unsigned d, input int unsigned len, input int unsigned total);
      drive_cfg(d, len, total);
      bus.Capture_En = 1'b1;
      step();
   endtask

   // One-cycle trigger pulse; config inputs are scrambled afterwards and must be ignored.
   task automatic pulse(input int unsigned low);
      bus.trigger_i = 1'b1;
      model_edge(cyc + 1);
      step();
      bus.trigger_i     = 1'b0;
      bus.delay_i       = DLY_W'($urandom);
      bus.frame_len_i   = LEN_W'($urandom);
      bus.pulse_total_i = CNT_W'($urandom);
      repeat (low) step();
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_dv"},    bus.data_valid_o,   0);
      chk({tag, "_cnt"},   bus.frame_cnt_o,    0);
      chk({tag, "_first"}, bus.first_frame_o,  0);
      chk({tag, "_done"},  bus.capture_done_o, 0);
      chk({tag, "_busy"},  bus.busy_o,         0);
      chk({tag, "_miss"},  bus.trig_miss_o,    0);
   endtask

   task automatic end_session();
      while (cyc < m_armed + 2) step();
      chk("end_frame_cnt", bus.frame_cnt_o, m_frames % CNT_MOD);
      chk("end_trig_miss", bus.trig_miss_o, m_miss);
      chk("end_done", bus.capture_done_o, (m_total != 0 && m_frames == m_total) ? 1 : 0);
      chk("end_busy", bus.busy_o, 0);
      bus.Capture_En = 1'b0;
      step();
      check_idle_outputs("abort");
   endtask

   // Monitor: measure each data_valid window and compare with the oldest prediction.
   bit          in_frame = 0;
   int unsigned f_start, f_len;
   bit          f_first;

   always @(negedge clk) begin : mon
      frame_t e;
      if (bus.data_valid_o === 1'b1) begin
         if (!in_frame) begin
            in_frame = 1;
            f_start  = cyc;
            f_len    = 1;
            f_first  = bus.first_frame_o;
         end else begin
            f_len++;
         end
      end else if (in_frame) begin
         in_frame = 0;
         chk("frame_expected", (expq.size() != 0) ? 1 : 0, 1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("frame_start", f_start, e.start);
            chk("frame_len", f_len, e.len);
            chk("frame_first", f_first, e.first);
            chk("frame_cnt_after", bus.frame_cnt_o, e.cnt);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      frame_t f;
      int unsigned a;
      rst = 1'b1;
      bus.Capture_En    = 1'b0;
      bus.trigger_i     = 1'b0;
      bus.delay_i       = '0;
      bus.frame_len_i   = '0;
      bus.pulse_total_i = '0;
      repeat (3) step();
      check_idle_outputs("reset");
      rst = 1'b0;
      step();

      // Two-pulse session ending in DONE.
      start_session(3, 5, 2);
      pulse(100);
      pulse(4);
      end_session();

      // Free-running one-cycle frames past the counter wrap.
      start_session(1, 0, 0);
      for (int unsigned i = 0; i < 17; i++) pulse(10);
      end_session();

      // Dense triggers drive the miss counter into saturation.
      start_session(0, 10, 0);
      for (int unsigned i = 0; i < 400; i++) pulse(1);
      end_session();

      // Abort in the third cycle of a len=8 window, then a fresh session.
      start_session(2, 8, 0);
      pulse(0);
      f = expq[expq.size() - 1];
      while (cyc < f.start + 2) step();
      a = cyc;
      bus.Capture_En = 1'b0;
      f = expq.pop_back();
      f.len = a - f.start + 1;
      f.cnt = 0;
      expq.push_back(f);
      step();
      check_idle_outputs("trunc");
      start_session(1, 3, 1);
      pulse(3);
      end_session();

      // Reset while in DELAY; trigger immediately after release.
      start_session(10, 4, 1);
      pulse(2);
      rst = 1'b1;
      void'(expq.pop_back());
      step();
      check_idle_outputs("midrst");
      rst = 1'b0;
      drive_cfg(10, 4, 1);
      pulse(2);
      end_session();

      // Randomized sessions.
      for (int unsigned s = 0; s < 6; s++) begin
         start_session($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 5));
         for (int unsigned i = 0; i < 25; i++) pulse($urandom_range(1, 15));
         end_session();
      end

      repeat (4) step();
      chk("queue_drained", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
